tristate_reg_bank: RTL and testbench
====================================

TRISTATE_REG_BANK -- requirements
Module: tristate_reg_bank

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- WIDTH, 8: data width in bits.
- DEPTH, 4: number of registers in the bank, legal range 2..16.
- TURN_CYCLES, 1: bus-turnaround dead cycles, legal range 0..3.
- AW = clog2(DEPTH): derived address width.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clock, in, 1: single clock; all sequential logic updates on the falling edge.
- reset_n, in, 1: asynchronous, active-low reset.
- wr_en, in, 1: write strobe.
- wr_addr, in, AW: write index.
- data_in, in, WIDTH: write data.
- drv_req, in, 1: request to own and drive the bus.
- drv_addr, in, AW: register to drive; sampled when the request is accepted.
- output_enable, in, 1: global drive gate.
- data_out, out, WIDTH: tristate bus output.
- drv_active, out, 1: high while in DRIVE.
- busy, out, 1: high in any state other than IDLE.

Function
REQ-003 On a falling edge with wr_en=1 and wr_addr<DEPTH, the block SHALL load data_in into bank[wr_addr].
- Writes with wr_addr>=DEPTH SHALL be ignored.

REQ-004 The FSM SHALL have exactly four states: IDLE, TURN_ON, DRIVE, TURN_OFF.

REQ-005 In IDLE with drv_req=1, the block SHALL capture drv_addr into sel_addr and move to TURN_ON.
- If TURN_CYCLES=0, it SHALL move directly to DRIVE.

REQ-006 TURN_ON SHALL last exactly TURN_CYCLES cycles, counted by a down-counter, and then move to DRIVE.
- If drv_req falls during TURN_ON, the block SHALL return to IDLE on that edge.
- The bus is never driven in this case.

REQ-007 In DRIVE, data_out SHALL equal bank[sel_addr] when output_enable=1, and all-Z otherwise.
- output_enable acts combinationally.
- drv_addr changes SHALL be ignored until the next request.

REQ-008 In DRIVE with drv_req=0, the block SHALL move to TURN_OFF.
- TURN_OFF lasts TURN_CYCLES cycles, then returns to IDLE.
- With TURN_CYCLES=0, the block goes directly to IDLE.
- A drv_req seen during TURN_OFF SHALL wait until IDLE.

REQ-009 data_out SHALL be all-Z in every state except DRIVE.

REQ-010 A write to bank[sel_addr] during DRIVE SHALL appear on data_out immediately after the writing edge (write-through, no stale hold).

REQ-011 If sel_addr>=DEPTH, DRIVE SHALL output all zeros (driven, not Z).

REQ-012 drv_active SHALL be registered state decode: high exactly for the cycles spent in DRIVE.

REQ-013 busy SHALL be high exactly for the cycles spent in TURN_ON, DRIVE or TURN_OFF.

REQ-014 Request-to-first-drive latency SHALL be TURN_CYCLES+1 falling edges, measured from the edge that samples drv_req=1.

Reset
REQ-015 Asserting reset_n=0 SHALL asynchronously do all of the following, including mid-operation:
- clear all bank entries to 0;
- set the FSM to IDLE;
- clear sel_addr and the turn counter;
- force data_out to all-Z, drv_active to 0 and busy to 0 without waiting for a clock edge.

REQ-016 After reset_n rises, the first state transition SHALL occur on the next falling edge.

Structure
REQ-017 The state enumeration and the constant TURN_MAX=3 SHALL live in the shared package tristate_pkg.

REQ-018 The FSM and turn counter SHALL be one sub-module, tristate_drv_fsm.
- The register bank and the tristate output mux SHALL remain in tristate_reg_bank.

Verification
REQ-019 The bench SHALL cover at least these directed scenarios:
- Basic write/drive: WIDTH=8, DEPTH=4, TURN_CYCLES=1. Write 0xA5 to addr 2, then drv_req=1 with drv_addr=2 -> data_out Z for 1 cycle, then 0xA5 with drv_active=1; drop drv_req -> 1 Z cycle, busy=0 after it.
- Zero turnaround: TURN_CYCLES=0 -> data_out=bank value on the first edge after the request; Z on the first edge after drv_req drops.
- Aborted turn-on: TURN_CYCLES=3, drv_req pulsed for 2 cycles -> data_out never leaves Z; back to IDLE.
- Write-through and gating: in DRIVE on addr 1, write 0x3C to addr 1 -> data_out=0x3C next cycle. output_enable=0 -> Z immediately, with drv_active still 1.
- Reset mid-DRIVE: reset_n=0 -> data_out Z and busy=0 without a clock edge. A subsequent drive of addr 2 outputs 0x00.

Source files
------------

// File: rtl/tristate_pkg.sv
// Shared definitions for the tristate register bank and its bus-ownership FSM.
package tristate_pkg;

    localparam int unsigned TURN_MAX = 3;
    localparam int unsigned CNT_W    = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TURN_ON  = 2'd1,
        DRIVE    = 2'd2,
        TURN_OFF = 2'd3
    } drv_state_e;

    // Turn counter load value: TURN_CYCLES-1, saturated to the supported range.
    function automatic logic [CNT_W-1:0] turn_load(input int unsigned turn_cycles);
        int unsigned eff;
        eff = (turn_cycles > TURN_MAX) ? TURN_MAX : turn_cycles;
        return (eff == 0) ? '0 : CNT_W'(eff - 1);
    endfunction

endpackage

// File: rtl/tristate_drv_fsm.sv
// Bus-ownership FSM: turn-on dead time, drive window, turn-off dead time.
module tristate_drv_fsm
    import tristate_pkg::*;
#(
    parameter int unsigned AW          = 2,
    parameter int unsigned TURN_CYCLES = 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          drv_req,
    input  logic [AW-1:0] drv_addr,
    output logic [AW-1:0] sel_addr,
    output logic          drv_active,
    output logic          busy
);

    localparam logic [CNT_W-1:0] TURN_LOAD = turn_load(TURN_CYCLES);
    localparam bit               NO_TURN   = (TURN_CYCLES == 0);

    drv_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [AW-1:0]    sel_addr_q;
    logic             drv_active_q;
    logic             busy_q;

    // Outputs are updated together with the state so they decode the registered state.
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sel_addr_q   <= '0;
            drv_active_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (drv_req) begin
                        sel_addr_q <= drv_addr;
                        busy_q     <= 1'b1;
                        if (NO_TURN) begin
                            state_q      <= DRIVE;
                            drv_active_q <= 1'b1;
                        end else begin
                            state_q <= TURN_ON;
                            cnt_q   <= TURN_LOAD;
                        end
                    end
                end
                TURN_ON: begin
                    if (!drv_req) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == '0) begin
                        state_q      <= DRIVE;
                        drv_active_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DRIVE: begin
                    if (!drv_req) begin
                        drv_active_q <= 1'b0;
                        if (NO_TURN) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= TURN_OFF;
                            cnt_q   <= TURN_LOAD;
                        end
                    end
                end
                TURN_OFF: begin
                    // Requests arriving here are honoured only once back in IDLE.
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    cnt_q        <= '0;
                    drv_active_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign sel_addr   = sel_addr_q;
    assign drv_active = drv_active_q;
    assign busy       = busy_q;

endmodule

// File: rtl/tristate_reg_bank.sv
// Register bank whose selected entry is driven onto a shared tristate bus.
module tristate_reg_bank
    import tristate_pkg::*;
#(
    parameter  int unsigned WIDTH       = 8,
    parameter  int unsigned DEPTH       = 4,
    parameter  int unsigned TURN_CYCLES = 1,
    localparam int unsigned AW          = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] data_in,
    input  logic             drv_req,
    input  logic [AW-1:0]    drv_addr,
    input  logic             output_enable,
    output wire  [WIDTH-1:0] data_out,
    output logic             drv_active,
    output logic             busy
);

    logic [WIDTH-1:0] bank_q [DEPTH];
    logic [AW-1:0]    sel_addr;
    logic [WIDTH-1:0] rd_data_c;

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= '0;
            end
        end else if (wr_en && (32'(wr_addr) < DEPTH)) begin
            bank_q[wr_addr] <= data_in;
        end
    end

    tristate_drv_fsm #(
        .AW          (AW),
        .TURN_CYCLES (TURN_CYCLES)
    ) u_drv_fsm (
        .clock      (clock),
        .reset_n    (reset_n),
        .drv_req    (drv_req),
        .drv_addr   (drv_addr),
        .sel_addr   (sel_addr),
        .drv_active (drv_active),
        .busy       (busy)
    );

    // Unbuffered read so a write to the selected entry shows up right after its edge.
    always_comb begin
        rd_data_c = '0;
        if (32'(sel_addr) < DEPTH) begin
            rd_data_c = bank_q[sel_addr];
        end
    end

    assign data_out = (drv_active && output_enable) ? rd_data_c : {WIDTH{1'bz}};

endmodule

// File: tb/tb_tristate_reg_bank.sv
// Directed bench: three bank instances (TURN_CYCLES 1, 0, 3) on shared stimulus.
module tb_tristate_reg_bank;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned AW    = 2;
    // Each bus carries a pull-up, so a released (Z) bus reads as all ones.
    localparam logic [WIDTH-1:0] BUS_IDLE = 8'hFF;

    logic             clock = 1'b1;
    logic             reset_n;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] data_in;
    logic             drv_req;
    logic [AW-1:0]    drv_addr;
    logic             output_enable;

    wire  [WIDTH-1:0] bus_tc1;
    wire  [WIDTH-1:0] bus_tc0;
    wire  [WIDTH-1:0] bus_tc3;
    logic             act_tc1, act_tc0, act_tc3;
    logic             busy_tc1, busy_tc0, busy_tc3;

    int n_vec = 0;
    int n_err = 0;

    pullup pu_tc1 (bus_tc1);
    pullup pu_tc0 (bus_tc0);
    pullup pu_tc3 (bus_tc3);

    always #5 clock = ~clock;

    tristate_reg_bank #(.WIDTH(8), .DEPTH(4), .TURN_CYCLES(1)) u_tc1 (
        .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .data_in(data_in), .drv_req(drv_req), .drv_addr(drv_addr),
        .output_enable(output_enable), .data_out(bus_tc1),
        .drv_active(act_tc1), .busy(busy_tc1)
    );

    // DEPTH=3 leaves address 3 out of range for the boundary cases.
    tristate_reg_bank #(.WIDTH(8), .DEPTH(3), .TURN_CYCLES(0)) u_tc0 (
        .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .data_in(data_in), .drv_req(drv_req), .drv_addr(drv_addr),
        .output_enable(output_enable), .data_out(bus_tc0),
        .drv_active(act_tc0), .busy(busy_tc0)
    );

    tristate_reg_bank #(.WIDTH(8), .DEPTH(4), .TURN_CYCLES(3)) u_tc3 (
        .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .data_in(data_in), .drv_req(drv_req), .drv_addr(drv_addr),
        .output_enable(output_enable), .data_out(bus_tc3),
        .drv_active(act_tc3), .busy(busy_tc3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change at the rising edge; the DUT samples at the following falling edge.
    task automatic step();
        @(negedge clock);
        @(posedge clock);
    endtask

    task automatic write_reg(input logic [AW-1:0] addr, input logic [WIDTH-1:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        data_in = data;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic settle();
        drv_req = 1'b0;
        repeat (5) step();
    endtask

    initial begin
        reset_n       = 1'b0;
        wr_en         = 1'b0;
        wr_addr       = '0;
        data_in       = '0;
        drv_req       = 1'b0;
        drv_addr      = '0;
        output_enable = 1'b1;

        repeat (2) @(posedge clock);
        check("rst_bus_tc1",  32'(bus_tc1),  32'(BUS_IDLE));
        check("rst_busy_tc1", 32'(busy_tc1), 32'd0);
        check("rst_act_tc1",  32'(act_tc1),  32'd0);
        check("rst_bus_tc0",  32'(bus_tc0),  32'(BUS_IDLE));
        reset_n = 1'b1;
        step();

        write_reg(2'd0, 8'h5A);
        write_reg(2'd1, 8'h11);
        write_reg(2'd2, 8'hA5);
        write_reg(2'd3, 8'h77);

        // Basic write/drive on TURN_CYCLES=1, zero turnaround observed on u_tc0
        drv_req  = 1'b1;
        drv_addr = 2'd2;
        step();
        check("s1_turnon_bus",  32'(bus_tc1),  32'(BUS_IDLE));
        check("s1_turnon_busy", 32'(busy_tc1), 32'd1);
        check("s1_turnon_act",  32'(act_tc1),  32'd0);
        check("s2_tc0_drive",   32'(bus_tc0),  32'hA5);
        check("s2_tc0_act",     32'(act_tc0),  32'd1);
        drv_addr = 2'd0;
        step();
        check("s1_drive_bus",   32'(bus_tc1),  32'hA5);
        check("s1_drive_act",   32'(act_tc1),  32'd1);
        step();
        check("s1_addr_ignored", 32'(bus_tc1), 32'hA5);
        drv_req = 1'b0;
        step();
        check("s1_turnoff_bus",  32'(bus_tc1),  32'(BUS_IDLE));
        check("s1_turnoff_busy", 32'(busy_tc1), 32'd1);
        check("s1_turnoff_act",  32'(act_tc1),  32'd0);
        check("s2_tc0_release",  32'(bus_tc0),  32'(BUS_IDLE));
        check("s2_tc0_idle",     32'(busy_tc0), 32'd0);
        step();
        check("s1_idle_busy", 32'(busy_tc1), 32'd0);
        settle();

        // Aborted turn-on with TURN_CYCLES=3
        drv_req  = 1'b1;
        drv_addr = 2'd2;
        step();
        check("s3_turnon_busy", 32'(busy_tc3), 32'd1);
        check("s3_turnon_bus",  32'(bus_tc3),  32'(BUS_IDLE));
        step();
        check("s3_turnon_bus2", 32'(bus_tc3),  32'(BUS_IDLE));
        drv_req = 1'b0;
        step();
        check("s3_abort_busy", 32'(busy_tc3), 32'd0);
        check("s3_abort_bus",  32'(bus_tc3),  32'(BUS_IDLE));
        step();
        check("s3_abort_act",  32'(act_tc3),  32'd0);
        settle();

        // Full TURN_CYCLES=3 drive: first drive four edges after the request
        drv_req = 1'b1;
        repeat (3) step();
        check("s3_latency_dead", 32'(bus_tc3), 32'(BUS_IDLE));
        step();
        check("s3_latency_drive", 32'(bus_tc3), 32'hA5);
        settle();

        // Write-through and output_enable gating on TURN_CYCLES=1
        drv_req  = 1'b1;
        drv_addr = 2'd1;
        repeat (2) step();
        check("s4_drive_old", 32'(bus_tc1), 32'h11);
        write_reg(2'd1, 8'h3C);
        check("s4_write_through", 32'(bus_tc1), 32'h3C);
        output_enable = 1'b0;
        #1;
        check("s4_gate_bus", 32'(bus_tc1), 32'(BUS_IDLE));
        check("s4_gate_act", 32'(act_tc1), 32'd1);
        output_enable = 1'b1;
        #1;
        check("s4_ungate_bus", 32'(bus_tc1), 32'h3C);
        settle();

        // Out-of-range select on DEPTH=3: write ignored, bus driven with zeros
        drv_req  = 1'b1;
        drv_addr = 2'd3;
        step();
        check("s5_oob_bus", 32'(bus_tc0), 32'h00);
        check("s5_oob_act", 32'(act_tc0), 32'd1);
        settle();

        // Asynchronous reset while driving
        drv_req  = 1'b1;
        drv_addr = 2'd2;
        repeat (2) step();
        check("s6_pre_bus", 32'(bus_tc1), 32'hA5);
        reset_n = 1'b0;
        #1;
        check("s6_rst_bus",  32'(bus_tc1),  32'(BUS_IDLE));
        check("s6_rst_busy", 32'(busy_tc1), 32'd0);
        check("s6_rst_act",  32'(act_tc1),  32'd0);
        @(posedge clock);
        reset_n = 1'b1;
        step();
        check("s6_first_edge_busy", 32'(busy_tc1), 32'd1);
        check("s6_tc0_cleared",     32'(bus_tc0),  32'h00);
        step();
        check("s6_tc1_cleared",     32'(bus_tc1),  32'h00);
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
